stream_threshold: RTL and testbench

- Streaming binariser for the camera pixel path: compares each incoming PIXEL_WIDTH-bit luma sample against an active threshold and emits one bit per pixel.
- Generalises the fixed four-level threshold with:
  - a programmable NUM_LEVELS threshold table;
  - an adaptive mode that uses the previous frame's mean luma;
  - valid/ready handshaking and per-frame threshold latching.
- Sits between the greyscale converter and the blob/centroid stage.

---
 rtl/stream_threshold_pkg.sv | 18 +
 rtl/threshold_mean_acc.sv | 51 +++++
 rtl/stream_threshold.sv | 133 +++++++++++++
 tb/tb_stream_threshold.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_threshold_pkg.sv
// Shared mode encoding and sizing helpers for the stream_threshold binariser.
package stream_threshold_pkg;

   typedef enum logic {
      THR_MODE_TABLE    = 1'b0,
      THR_MODE_ADAPTIVE = 1'b1
   } thr_mode_e;

   function automatic int acc_width(input int pixel_width, input int log2_frame_pixels);
      return pixel_width + log2_frame_pixels;
   endfunction

   // Evenly spaced levels strictly inside the pixel range.
   function automatic int default_level(input int k, input int pixel_width, input int num_levels);
      return ((k + 1) * (1 << pixel_width)) / (num_levels + 1);
   endfunction

endpackage

// File: rtl/threshold_mean_acc.sv
// Saturating per-frame luma accumulator; publishes the clamped frame mean
// as the adaptive threshold when the last pixel of a frame is accepted.
module threshold_mean_acc
   import stream_threshold_pkg::*;
#(
   parameter int PIXEL_WIDTH       = 7,
   parameter int LOG2_FRAME_PIXELS = 16
) (
   input  logic                   clk_in,
   input  logic                   rst_n_in,
   input  logic                   accept_in,
   input  logic                   last_in,
   input  logic [PIXEL_WIDTH-1:0] pixel_in,
   output logic [PIXEL_WIDTH-1:0] adaptive_thresh_out
);

   localparam int ACC_WIDTH = acc_width(PIXEL_WIDTH, LOG2_FRAME_PIXELS);
   localparam int SUM_W     = ACC_WIDTH + 1;
   localparam logic [PIXEL_WIDTH-1:0] MID_LEVEL = PIXEL_WIDTH'(1 << (PIXEL_WIDTH - 1));

   logic [ACC_WIDTH-1:0] acc_q;
   logic [SUM_W-1:0]     sum_p0;

   function automatic logic [ACC_WIDTH-1:0] sat_acc(input logic [SUM_W-1:0] s);
      return s[ACC_WIDTH] ? '1 : s[ACC_WIDTH-1:0];
   endfunction

   function automatic logic [PIXEL_WIDTH-1:0] clamp_mean(input logic [SUM_W-1:0] s);
      logic [SUM_W-1:0] m;
      m = s >> LOG2_FRAME_PIXELS;
      return (m > SUM_W'({PIXEL_WIDTH{1'b1}})) ? '1 : m[PIXEL_WIDTH-1:0];
   endfunction

   assign sum_p0 = {1'b0, acc_q} + SUM_W'(pixel_in);

   // Stage p0 -> registered accumulator and mean
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         acc_q               <= '0;
         adaptive_thresh_out <= MID_LEVEL;
      end else if (accept_in) begin
         if (last_in) begin
            adaptive_thresh_out <= clamp_mean(sum_p0);
            acc_q               <= '0;
         end else begin
            acc_q <= sat_acc(sum_p0);
         end
      end
   end

endmodule

// File: rtl/stream_threshold.sv
// Streaming luma binariser with per-frame latched table/adaptive threshold.
// Optional macro STREAM_THRESHOLD_COUNT_EN adds a per-frame ones counter.
module stream_threshold
   import stream_threshold_pkg::*;
#(
   parameter  int PIXEL_WIDTH       = 7,
   parameter  int NUM_LEVELS        = 4,
   parameter  int LOG2_FRAME_PIXELS = 16,
   localparam int SEL_WIDTH         = $clog2(NUM_LEVELS),
   localparam int ACC_WIDTH         = acc_width(PIXEL_WIDTH, LOG2_FRAME_PIXELS)
) (
   input  logic                   clk_in,
   input  logic                   rst_n_in,
   input  logic [PIXEL_WIDTH-1:0] pixel_in,
   input  logic                   pixel_valid_in,
   input  logic                   pixel_last_in,
   output logic                   pixel_ready_out,
   input  logic                   mode_in,
   input  logic [SEL_WIDTH-1:0]   level_sel_in,
   input  logic                   cfg_we_in,
   input  logic [SEL_WIDTH-1:0]   cfg_addr_in,
   input  logic [PIXEL_WIDTH-1:0] cfg_data_in,
   output logic                   bit_out,
   output logic                   bit_valid_out,
   output logic                   bit_last_out,
   input  logic                   bit_ready_in,
   output logic [PIXEL_WIDTH-1:0] thresh_active_out
`ifdef STREAM_THRESHOLD_COUNT_EN
   ,
   output logic [ACC_WIDTH-1:0]   ones_count_out,
   output logic                   ones_count_valid_out
`endif
);

   logic                   vld_p1, bit_p1, last_p1;
   logic                   frame_start_q;
   logic [PIXEL_WIDTH-1:0] tbl_q [NUM_LEVELS];
   logic [PIXEL_WIDTH-1:0] thresh_q, adaptive_thresh;
   logic [PIXEL_WIDTH-1:0] new_thr_p0, cmp_thr_p0;
   logic [SEL_WIDTH-1:0]   sel_p0;
   logic                   accept_p0;

   assign pixel_ready_out = !vld_p1 || bit_ready_in;
   assign accept_p0       = pixel_valid_in && pixel_ready_out;

   assign sel_p0     = (int'(level_sel_in) >= NUM_LEVELS) ? SEL_WIDTH'(NUM_LEVELS - 1) : level_sel_in;
   assign new_thr_p0 = (thr_mode_e'(mode_in) == THR_MODE_ADAPTIVE) ? adaptive_thresh : tbl_q[sel_p0];
   // The frame-start pixel is compared against the threshold being latched now.
   assign cmp_thr_p0 = frame_start_q ? new_thr_p0 : thresh_q;

   assign bit_out           = bit_p1;
   assign bit_valid_out     = vld_p1;
   assign bit_last_out      = last_p1;
   assign thresh_active_out = thresh_q;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int k = 0; k < NUM_LEVELS; k++)
            tbl_q[k] <= PIXEL_WIDTH'(default_level(k, PIXEL_WIDTH, NUM_LEVELS));
      end else if (cfg_we_in && int'(cfg_addr_in) < NUM_LEVELS) begin
         tbl_q[cfg_addr_in] <= cfg_data_in;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         frame_start_q <= 1'b1;
         thresh_q      <= PIXEL_WIDTH'(default_level(0, PIXEL_WIDTH, NUM_LEVELS));
      end else if (accept_p0) begin
         frame_start_q <= pixel_last_in;
         if (frame_start_q)
            thresh_q <= new_thr_p0;
      end
   end

   // Stage p0 -> p1: single output register
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         vld_p1  <= 1'b0;
         bit_p1  <= 1'b0;
         last_p1 <= 1'b0;
      end else if (accept_p0) begin
         vld_p1  <= 1'b1;
         bit_p1  <= (pixel_in > cmp_thr_p0);
         last_p1 <= pixel_last_in;
      end else if (bit_ready_in) begin
         vld_p1 <= 1'b0;
      end
   end

   threshold_mean_acc #(
      .PIXEL_WIDTH       (PIXEL_WIDTH),
      .LOG2_FRAME_PIXELS (LOG2_FRAME_PIXELS)
   ) u_mean_acc (
      .clk_in              (clk_in),
      .rst_n_in            (rst_n_in),
      .accept_in           (accept_p0),
      .last_in             (pixel_last_in),
      .pixel_in            (pixel_in),
      .adaptive_thresh_out (adaptive_thresh)
   );

`ifdef STREAM_THRESHOLD_COUNT_EN
   logic                 out_fire;
   logic [ACC_WIDTH-1:0] ones_run_q;

   function automatic logic [ACC_WIDTH-1:0] sat_inc(input logic [ACC_WIDTH-1:0] c, input logic b);
      return (b && (c != '1)) ? c + ACC_WIDTH'(1) : c;
   endfunction

   assign out_fire = vld_p1 && bit_ready_in;

   // Stage p1 -> frame summary, counted on the output handshake
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         ones_run_q           <= '0;
         ones_count_out       <= '0;
         ones_count_valid_out <= 1'b0;
      end else begin
         ones_count_valid_out <= out_fire && last_p1;
         if (out_fire) begin
            if (last_p1) begin
               ones_count_out <= sat_inc(ones_run_q, bit_p1);
               ones_run_q     <= '0;
            end else begin
               ones_run_q <= sat_inc(ones_run_q, bit_p1);
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_stream_threshold.sv
// Self-checking bench for stream_threshold: directed steps plus random traffic
// against a behavioural frame-level model. Define STREAM_THRESHOLD_COUNT_EN to cover the counter.
module tb_stream_threshold;

   localparam int PW      = 7;
   localparam int NL      = 4;
   localparam int L2      = 2;
   localparam int AW      = PW + L2;
   localparam int PIX_MAX = (1 << PW) - 1;
   localparam int ACC_MAX = (1 << AW) - 1;

   logic          clk_in = 1'b0;
   logic          rst_n_in = 1'b0;
   logic [PW-1:0] pixel_in = '0;
   logic          pixel_valid_in = 1'b0;
   logic          pixel_last_in = 1'b0;
   logic          pixel_ready_out;
   logic          mode_in = 1'b0;
   logic [1:0]    level_sel_in = '0;
   logic          cfg_we_in = 1'b0;
   logic [1:0]    cfg_addr_in = '0;
   logic [PW-1:0] cfg_data_in = '0;
   logic          bit_out, bit_valid_out, bit_last_out;
   logic          bit_ready_in = 1'b1;
   logic [PW-1:0] thresh_active_out;
`ifdef STREAM_THRESHOLD_COUNT_EN
   logic [AW-1:0] ones_count_out;
   logic          ones_count_valid_out;
`endif

   stream_threshold #(
      .PIXEL_WIDTH       (PW),
      .NUM_LEVELS        (NL),
      .LOG2_FRAME_PIXELS (L2)
   ) dut (
      .clk_in            (clk_in),
      .rst_n_in          (rst_n_in),
      .pixel_in          (pixel_in),
      .pixel_valid_in    (pixel_valid_in),
      .pixel_last_in     (pixel_last_in),
      .pixel_ready_out   (pixel_ready_out),
      .mode_in           (mode_in),
      .level_sel_in      (level_sel_in),
      .cfg_we_in         (cfg_we_in),
      .cfg_addr_in       (cfg_addr_in),
      .cfg_data_in       (cfg_data_in),
      .bit_out           (bit_out),
      .bit_valid_out     (bit_valid_out),
      .bit_last_out      (bit_last_out),
      .bit_ready_in      (bit_ready_in),
      .thresh_active_out (thresh_active_out)
`ifdef STREAM_THRESHOLD_COUNT_EN
      ,
      .ones_count_out       (ones_count_out),
      .ones_count_valid_out (ones_count_valid_out)
`endif
   );

   always #5 clk_in = ~clk_in;

   int n_cmp  = 0;
   int n_fail = 0;

   // Behavioural model state
   int m_tbl [NL];
   int m_adapt, m_acc, m_thr, m_run, m_ones;
   bit m_fs, m_vld, m_bit, m_last, m_ones_vld;

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
         $error("check %s did not hold", tag);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < NL; k++) m_tbl[k] = ((k + 1) * (PIX_MAX + 1)) / (NL + 1);
      m_adapt = (PIX_MAX + 1) / 2;
      m_acc = 0; m_thr = m_tbl[0]; m_fs = 1;
      m_vld = 0; m_bit = 0; m_last = 0;
      m_run = 0; m_ones = 0; m_ones_vld = 0;
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".valid"}, 32'(bit_valid_out), 32'(m_vld));
      check({tag, ".bit"}, 32'(bit_out), 32'(m_bit));
      check({tag, ".last"}, 32'(bit_last_out), 32'(m_last));
      check({tag, ".thr"}, 32'(thresh_active_out), 32'(m_thr));
`ifdef STREAM_THRESHOLD_COUNT_EN
      check({tag, ".cnt_vld"}, 32'(ones_count_valid_out), 32'(m_ones_vld));
      check({tag, ".cnt"}, 32'(ones_count_out), 32'(m_ones));
`endif
   endtask

   // One clock: apply inputs, check ready, advance model and DUT, check outputs.
   task automatic step(input string tag, input bit v, input int pix, input bit l, input bit br);
      bit exp_ready, acc;
      int sel, newthr, thr;
      pixel_valid_in = v; pixel_in = PW'(pix); pixel_last_in = l; bit_ready_in = br;
      #1;
      exp_ready = !m_vld || br;
      check({tag, ".ready"}, 32'(pixel_ready_out), 32'(exp_ready));
      acc = v && exp_ready;
      m_ones_vld = 0;
      if (m_vld && br) begin
         if (m_bit) m_run = imin(m_run + 1, ACC_MAX);
         if (m_last) begin m_ones = m_run; m_run = 0; m_ones_vld = 1; end
      end
      if (acc) begin
         sel    = imin(int'(level_sel_in), NL - 1);
         newthr = mode_in ? m_adapt : m_tbl[sel];
         thr    = m_fs ? newthr : m_thr;
         if (m_fs) m_thr = newthr;
         m_fs = l; m_vld = 1; m_bit = (pix > thr); m_last = l;
         if (l) begin
            m_adapt = imin((m_acc + pix) >> L2, PIX_MAX);
            m_acc = 0;
         end else begin
            m_acc = imin(m_acc + pix, ACC_MAX);
         end
      end else if (br) begin
         m_vld = 0;
      end
      if (cfg_we_in && int'(cfg_addr_in) < NL) m_tbl[cfg_addr_in] = int'(cfg_data_in);
      @(posedge clk_in); #1;
      cfg_we_in = 1'b0;
      check_outputs(tag);
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk_in);
      #1;
      check("reset.valid", 32'(bit_valid_out), 32'd0);
      check("reset.bit", 32'(bit_out), 32'd0);
      check("reset.last", 32'(bit_last_out), 32'd0);
      check("reset.thr", 32'(thresh_active_out), 32'd25);
      rst_n_in = 1'b1;

      // Table level 2 (76): strictly greater-than at the boundary
      mode_in = 1'b0; level_sel_in = 2'd2;
      step("t1a", 1, 76, 0, 1);
      check("t1a.bit_eq_thr", 32'(bit_out), 32'd0);
      check("t1a.thr76", 32'(thresh_active_out), 32'd76);
      step("t1b", 1, 77, 0, 1);
      check("t1b.bit", 32'(bit_out), 32'd1);
      step("t1c", 1, 127, 1, 1);
      check("t1c.bit", 32'(bit_out), 32'd1);
      check("t1c.last", 32'(bit_last_out), 32'd1);

      // Backpressure: held output, no accept, pending pixel taken on release
      step("t2a", 1, 100, 0, 1);
      for (int i = 0; i < 5; i++) begin
         step("t2stall", 1, 10, 0, 0);
         check("t2stall.ready", 32'(pixel_ready_out), 32'd0);
         check("t2stall.bit_hold", 32'(bit_out), 32'd1);
      end
      step("t2rel", 1, 10, 1, 1);
      check("t2rel.bit", 32'(bit_out), 32'd0);

      // Mid-frame table write only takes effect at the next frame latch
      level_sel_in = 2'd1;
      step("t3a", 1, 60, 0, 1);
      check("t3a.thr51", 32'(thresh_active_out), 32'd51);
      cfg_we_in = 1'b1; cfg_addr_in = 2'd1; cfg_data_in = 7'd10;
      step("t3b", 1, 30, 0, 1);
      step("t3c", 1, 30, 1, 1);
      check("t3c.old_thr", 32'(bit_out), 32'd0);
      step("t3d", 1, 30, 1, 1);
      check("t3d.thr10", 32'(thresh_active_out), 32'd10);
      check("t3d.bit", 32'(bit_out), 32'd1);

      // Mean of 40,40,40,44 over 4 pixels -> 41 in adaptive mode
      step("t4a", 1, 40, 0, 1);
      step("t4b", 1, 40, 0, 1);
      step("t4c", 1, 40, 0, 1);
      step("t4d", 1, 44, 1, 1);
      mode_in = 1'b1;
      step("t4e", 1, 41, 0, 1);
      check("t4e.thr41", 32'(thresh_active_out), 32'd41);
      check("t4e.bit", 32'(bit_out), 32'd0);
      step("t4f", 1, 42, 1, 1);
      check("t4f.bit", 32'(bit_out), 32'd1);

      // Asynchronous reset mid-frame with an output pending
      step("t5a", 1, 100, 0, 1);
      rst_n_in = 1'b0;
      #1;
      model_reset();
      check("t5rst.valid", 32'(bit_valid_out), 32'd0);
      check("t5rst.bit", 32'(bit_out), 32'd0);
      check("t5rst.thr", 32'(thresh_active_out), 32'd25);
      @(posedge clk_in); #1;
      rst_n_in = 1'b1;
      step("t5b", 1, 70, 0, 1);
      check("t5b.thr64", 32'(thresh_active_out), 32'd64);
      step("t5c", 1, 60, 1, 1);
      step("t5d", 1, 33, 1, 1);
      check("t5d.thr32", 32'(thresh_active_out), 32'd32);

      // Eight-pixel frame at table level 0 (25) with three pixels above it
      mode_in = 1'b0; level_sel_in = 2'd0;
      step("t6p0", 1, 30, 0, 1);
      step("t6p1", 1, 10, 0, 1);
      step("t6p2", 1, 26, 0, 1);
      step("t6p3", 1, 25, 0, 1);
      step("t6p4", 1, 0, 0, 1);
      step("t6p5", 1, 127, 0, 1);
      step("t6p6", 1, 5, 0, 1);
      step("t6p7", 1, 20, 1, 1);
      step("t6drain", 0, 0, 0, 1);
`ifdef STREAM_THRESHOLD_COUNT_EN
      check("t6.cnt_vld", 32'(ones_count_valid_out), 32'd1);
      check("t6.cnt3", 32'(ones_count_out), 32'd3);
`endif
      step("t6idle", 0, 0, 0, 1);
`ifdef STREAM_THRESHOLD_COUNT_EN
      check("t6.cnt_pulse_end", 32'(ones_count_valid_out), 32'd0);
`endif

      // Random traffic, configuration writes and mode switches
      for (int i = 0; i < 400; i++) begin
         mode_in      = 1'($urandom_range(0, 1));
         level_sel_in = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) begin
            cfg_we_in   = 1'b1;
            cfg_addr_in = 2'($urandom_range(0, 3));
            cfg_data_in = 7'($urandom_range(0, PIX_MAX));
         end
         step("rnd", $urandom_range(0, 3) != 0, int'($urandom_range(0, PIX_MAX)),
              $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
      end
      step("drain0", 0, 0, 0, 1);
      step("drain1", 0, 0, 0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
